// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip RAM arbiter: RAM geometry, port id, request bundle.
// No logic, so no latency and no backpressure.
package onchip_mem_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_DEPTH  = 1024;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic                  write;
    } mem_req_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter, combinational grant (0 cycles); i_en low blocks all grants.
// The port not granted last wins a tie; last_grant resets to port 1 so port 0 wins first contention.
module rr_arb2
    import onchip_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    port_id_t   r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req[0] && (!i_req[1] || r_last == PORT1)) begin
                w_gnt = 2'b01;
            end else if (i_req[1]) begin
                w_gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= PORT1;
        end else if (w_gnt[0]) begin
            r_last <= PORT0;
        end else if (w_gnt[1]) begin
            r_last <= PORT1;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port RAM between two Avalon-MM requesters; accept is combinational, read data returns 1 cycle later.
// Losing port (or both, under reset/freeze) sees waitrequest; a dropped or frozen port simply retries.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic [CNT_W-1:0]  m0_grant_cnt,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [CNT_W-1:0]  m1_grant_cnt,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_block;
    logic       w_rd_gnt;
    mem_req_t   w_req_p0;
    mem_req_t   w_req_p1;
    mem_req_t   w_sel;

    logic             r_rd_pend;
    port_id_t         r_rd_owner;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    assign w_req   = {m1_read | m1_write, m0_read | m0_write};
    assign w_block = reset | freeze;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .i_en  (~w_block),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign m0_waitrequest = w_block | (w_req[0] & ~w_gnt[0]);
    assign m1_waitrequest = w_block | (w_req[1] & ~w_gnt[1]);

    // Write takes precedence when a requester raises read and write together.
    assign w_req_p0 = '{addr: m0_address, wdata: m0_writedata, write: m0_write};
    assign w_req_p1 = '{addr: m1_address, wdata: m1_writedata, write: m1_write};

    always_comb begin
        w_sel = '0;
        if (w_gnt[0]) begin
            w_sel = w_req_p0;
        end else if (w_gnt[1]) begin
            w_sel = w_req_p1;
        end
    end

    assign mem_address    = w_sel.addr;
    assign mem_writedata  = w_sel.wdata;
    assign mem_write      = w_sel.write;
    assign mem_chipselect = |w_gnt;
    assign mem_clken      = 1'b1;

    assign w_rd_gnt = (w_gnt[0] & m0_read & ~m0_write) | (w_gnt[1] & m1_read & ~m1_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= PORT0;
        end else begin
            r_rd_pend <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_owner <= w_gnt[1] ? PORT1 : PORT0;
            end
        end
    end

    // Gating with reset drops a response whose read was granted just before reset.
    assign m0_readdatavalid = r_rd_pend & ~reset & (r_rd_owner == PORT0);
    assign m1_readdatavalid = r_rd_pend & ~reset & (r_rd_owner == PORT1);
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt[0] && r_cnt0 != '1) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_gnt[1] && r_cnt1 != '1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign m0_grant_cnt = r_cnt0;
    assign m1_grant_cnt = r_cnt1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1024x8 RAM (registered read) on the mem_* side.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic [9:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [7:0]  m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [7:0]  m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_grant_cnt, m1_grant_cnt;
    logic [9:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [7:0]  mem_writedata;
    logic [7:0]  mem_readdata;

    logic [7:0]  ram [0:1023];
    logic [7:0]  ram_q = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .freeze           (freeze),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_grant_cnt     (m0_grant_cnt),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_grant_cnt     (m1_grant_cnt),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) ram[mem_address] <= mem_writedata;
            else           ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze = 1'b0;
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_read = 1'b1; m0_address = 10'h001;
        m1_write = 1'b1; m1_address = 10'h002;
        @(negedge clk);
        n_checks++; if (m0_waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_wr0: got %b want 1", m0_waitrequest); end
        n_checks++; if (m1_waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_wr1: got %b want 1", m1_waitrequest); end
        n_checks++; if (mem_chipselect !== 1'b0) begin n_errors++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_errors++; $display("FAIL reset_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
        n_checks++; if ({m0_readdata, m1_readdata} !== 16'h0000) begin n_errors++; $display("FAIL reset_rdata: got %h want 0000", {m0_readdata, m1_readdata}); end
        n_checks++; if ({m0_grant_cnt, m1_grant_cnt} !== 32'h0) begin n_errors++; $display("FAIL reset_cnt: got %h want 0", {m0_grant_cnt, m1_grant_cnt}); end
        tick();
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        m0_write = 1'b1; m0_address = 10'h005; m0_writedata = 8'hA5;
        @(negedge clk);
        n_checks++; if (m0_waitrequest !== 1'b0) begin n_errors++; $display("FAIL wr_accept: got %b want 0", m0_waitrequest); end
        n_checks++; if ({mem_chipselect, mem_write, mem_address, mem_writedata} !== {1'b1, 1'b1, 10'h005, 8'hA5}) begin
            n_errors++; $display("FAIL wr_mem_bus: got cs%b we%b a%h d%h want cs1 we1 a005 da5", mem_chipselect, mem_write, mem_address, mem_writedata);
        end
        tick();
        m0_write = 1'b0; m0_read = 1'b1;
        @(negedge clk);
        n_checks++; if (m0_waitrequest !== 1'b0) begin n_errors++; $display("FAIL rd_accept: got %b want 0", m0_waitrequest); end
        n_checks++; if (m0_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL rd_early_valid: got %b want 0", m0_readdatavalid); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 8'hA5) begin
            n_errors++; $display("FAIL rd_resp: got v%b d%h want v1 da5", m0_readdatavalid, m0_readdata);
        end
        n_checks++; if (m1_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL rd_resp_other: got %b want 0", m1_readdatavalid); end
        n_checks++; if (m0_grant_cnt !== 16'd2) begin n_errors++; $display("FAIL wr_rd_cnt: got %0d want 2", m0_grant_cnt); end
        tick();
        @(negedge clk);
        n_checks++; if (m0_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL rd_one_pulse: got %b want 0", m0_readdatavalid); end
    endtask

    task automatic test_alternate();
        int pulses0 = 0;
        int pulses1 = 0;
        m0_write = 1'b1; m0_address = 10'h010; m0_writedata = 8'h4A;
        tick();
        idle_inputs();
        m1_write = 1'b1; m1_address = 10'h020; m1_writedata = 8'h7A;
        tick();
        pulse_reset();
        m0_read = 1'b1; m0_address = 10'h010;
        m1_read = 1'b1; m1_address = 10'h020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if ({m1_waitrequest, m0_waitrequest} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_errors++; $display("FAIL alt_grant[%0d]: got wr1/wr0=%b%b want %b", i, m1_waitrequest, m0_waitrequest, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            n_checks++; if ({m1_readdatavalid, m0_readdatavalid} !== ((i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10))) begin
                n_errors++; $display("FAIL alt_valid[%0d]: got %b%b", i, m1_readdatavalid, m0_readdatavalid);
            end
            if (m0_readdatavalid) begin
                pulses0++;
                n_checks++; if (m0_readdata !== 8'h4A) begin n_errors++; $display("FAIL alt_data0[%0d]: got %h want 4a", i, m0_readdata); end
            end
            if (m1_readdatavalid) begin
                pulses1++;
                n_checks++; if (m1_readdata !== 8'h7A) begin n_errors++; $display("FAIL alt_data1[%0d]: got %h want 7a", i, m1_readdata); end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        if (m1_readdatavalid) pulses1++;
        n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 8'h7A) begin
            n_errors++; $display("FAIL alt_last: got v%b d%h want v1 d7a", m1_readdatavalid, m1_readdata);
        end
        n_checks++; if (pulses0 !== 3 || pulses1 !== 3) begin n_errors++; $display("FAIL alt_pulses: got %0d/%0d want 3/3", pulses0, pulses1); end
        n_checks++; if (m0_grant_cnt !== 16'd3 || m1_grant_cnt !== 16'd3) begin
            n_errors++; $display("FAIL alt_cnt: got %0d/%0d want 3/3", m0_grant_cnt, m1_grant_cnt);
        end
        tick();
    endtask

    task automatic test_same_addr();
        m0_write = 1'b1; m0_address = 10'h3FF; m0_writedata = 8'h11;
        tick();
        pulse_reset();
        m0_read = 1'b1; m0_address = 10'h3FF;
        m1_write = 1'b1; m1_address = 10'h3FF; m1_writedata = 8'h3C;
        @(negedge clk);
        n_checks++; if ({m0_waitrequest, m1_waitrequest, mem_write} !== 3'b010) begin
            n_errors++; $display("FAIL same_first: got wr0%b wr1%b we%b want 0 1 0", m0_waitrequest, m1_waitrequest, mem_write);
        end
        tick();
        m0_read = 1'b0;
        @(negedge clk);
        n_checks++; if ({m1_waitrequest, mem_write} !== 2'b01) begin
            n_errors++; $display("FAIL same_second: got wr1%b we%b want 0 1", m1_waitrequest, mem_write);
        end
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 8'h11) begin
            n_errors++; $display("FAIL same_old: got v%b d%h want v1 d11", m0_readdatavalid, m0_readdata);
        end
        tick();
        idle_inputs();
        m0_read = 1'b1; m0_address = 10'h3FF;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 8'h3C) begin
            n_errors++; $display("FAIL same_new: got v%b d%h want v1 d3c", m0_readdatavalid, m0_readdata);
        end
        tick();
    endtask

    task automatic test_freeze();
        m0_read = 1'b1; m0_address = 10'h3FF;
        tick();
        freeze = 1'b1;
        m0_address = 10'h010;
        m1_read = 1'b1; m1_address = 10'h020;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if ({m0_waitrequest, m1_waitrequest, mem_chipselect} !== 3'b110) begin
                n_errors++; $display("FAIL frz_block[%0d]: got wr0%b wr1%b cs%b want 1 1 0", i, m0_waitrequest, m1_waitrequest, mem_chipselect);
            end
            n_checks++; if (m0_readdatavalid !== (i == 0) || (i == 0 && m0_readdata !== 8'h3C)) begin
                n_errors++; $display("FAIL frz_resp[%0d]: got v%b d%h", i, m0_readdatavalid, m0_readdata);
            end
            tick();
        end
        freeze = 1'b0;
        @(negedge clk);
        n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin
            n_errors++; $display("FAIL frz_resume: got wr0%b wr1%b want 1 0", m0_waitrequest, m1_waitrequest);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 8'h7A) begin
            n_errors++; $display("FAIL frz_after: got v%b d%h want v1 d7a", m1_readdatavalid, m1_readdata);
        end
        tick();
    endtask

    task automatic test_reset_drop();
        m1_read = 1'b1; m1_address = 10'h020;
        @(negedge clk);
        n_checks++; if (m1_waitrequest !== 1'b0) begin n_errors++; $display("FAIL drop_grant: got %b want 0", m1_waitrequest); end
        tick();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (m1_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL drop_valid_rst: got %b want 0", m1_readdatavalid); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (m1_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL drop_valid_after: got %b want 0", m1_readdatavalid); end
        n_checks++; if (m0_grant_cnt !== 16'd0 || m1_grant_cnt !== 16'd0) begin
            n_errors++; $display("FAIL drop_cnt: got %0d/%0d want 0/0", m0_grant_cnt, m1_grant_cnt);
        end
        tick();
        m0_read = 1'b1; m0_address = 10'h010;
        m1_read = 1'b1; m1_address = 10'h020;
        @(negedge clk);
        n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
            n_errors++; $display("FAIL drop_next: got wr0%b wr1%b want 0 1", m0_waitrequest, m1_waitrequest);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 8'h4A) begin
            n_errors++; $display("FAIL drop_next_data: got v%b d%h want v1 d4a", m0_readdatavalid, m0_readdata);
        end
        tick();
    endtask

    task automatic test_saturation();
        pulse_reset();
        m0_write = 1'b1; m0_address = 10'h100; m0_writedata = 8'h00;
        repeat (65534) tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (m0_grant_cnt !== 16'hFFFE) begin n_errors++; $display("FAIL sat_pre: got %h want fffe", m0_grant_cnt); end
        tick();
        m0_write = 1'b1; m0_address = 10'h100;
        repeat (3) tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (m0_grant_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold: got %h want ffff", m0_grant_cnt); end
        n_checks++; if (m1_grant_cnt !== 16'h0000) begin n_errors++; $display("FAIL sat_other: got %h want 0000", m1_grant_cnt); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_write_read();
        test_alternate();
        test_same_addr();
        test_freeze();
        test_reset_drop();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 1024×8 on-chip RAM between two Avalon-MM-style requesters. It sits between the interconnect masters and the RAM wrapper, and drives that wrapper's address, chipselect, write, writedata and clken inputs. It also routes each one-cycle-latency read response back to the requester that issued it, and keeps saturating per-port grant counters for debug.

## Interface
Parameters:
- ADDR_W, 10, RAM address width (1024 words)
- DATA_W, 8, data width
- CNT_W, 16, width of the per-port grant counters

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- freeze  in  1  when high, no new grants; in-flight read still completes
- mN_address  in  ADDR_W  requester N word address (N = 0, 1)
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- mN_grant_cnt  out  CNT_W  saturating count of accepted transactions
- mem_address  out  ADDR_W  to RAM address
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; tied 1
- mem_readdata  in  DATA_W  from RAM readdata (unregistered output)

## Operation
- reqN = mN_read | mN_write. When both are high, the transaction is treated as a write; it is counted once.
- Arbitration is combinational each cycle and grants at most one port.
  - A single requesting port wins.
  - When both ports request, the port that is not last_grant wins.
  - last_grant updates only on a grant. Reset value is 1, so port 0 wins the first contention.
- mN_waitrequest = ~(grantN) whenever reqN is high. It is 1 for both ports while reset or freeze is high. When reqN is low it is 0 (don't-care).
- The granted port's address and writedata are muxed to mem_*, with mem_chipselect = 1 and mem_write = granted write.
- With no grant: mem_chipselect = 0, mem_write = 0, mem_address and mem_writedata = 0.
- Read tracking:
  - A granted read sets rd_pend_q = 1 and rd_owner_q = granted port.
  - On the next cycle, m{rd_owner_q}_readdatavalid = 1 and mN_readdata = mem_readdata.
  - The other port's readdata is 0.
- Writes produce no response.
- Grant counters increment on every accepted transaction and saturate at 2^CNT_W − 1.

## Timing
- Accept throughput is one transaction per cycle; a back-to-back mix of reads and writes from either port is legal.
- Read latency: request accepted at edge k → readdatavalid high for exactly one cycle after edge k+1 (1 cycle).
- Responses return in grant order. No queue is needed because latency is fixed.
- Reset values (registered outputs and state): readdatavalid 0, readdata 0, counters 0, rd_pend_q 0, last_grant 1.
- Reset asserted in the cycle after a read grant: the pending read is dropped and readdatavalid stays 0.
- Freeze rising while a read is pending: the response is still delivered. No new grant is made until freeze falls, and the grant is then in the same cycle.
- Simultaneous write (port 0) and read (port 1) at the same address: serialized by arbitration, and the read returns data according to grant order.

## Structure
- Shared package onchip_mem_pkg:
  - constants: MEM_ADDR_W = 10, MEM_DATA_W = 8, MEM_DEPTH = 1024
  - typedef port_id_t (1-bit)
  - typedef mem_req_t {addr, wdata, write}
- One sub-module: rr_arb2 (2-input round-robin arbiter with last_grant register).
- Everything else stays in the top: muxing, response tracking and counters.

## Test plan
- Port 0 write addr 0x005 data 0xA5, then read 0x005 → waitrequest 0 both cycles; m0_readdatavalid exactly 1 cycle after the read grant with data 0xA5; m0_grant_cnt = 2.
- Both ports read continuously for 6 cycles → grants alternate 0,1,0,1,0,1; each port receives 3 readdatavalid pulses in order.
- Port 1 write 0x3FF←0x3C while port 0 reads 0x3FF in the same cycle, after reset → port 0 wins and returns the old value; the port 1 write is accepted the next cycle; a later read returns 0x3C.
- Freeze high for 4 cycles with both requesting, read pending at freeze entry → the pending response delivered; zero grants and waitrequest 1 during freeze; port-order grant resumes the cycle freeze drops.
- Reset pulsed the cycle after port 1 read grant → no m1_readdatavalid; counters 0; next contention won by port 0.
- Force m0_grant_cnt to 0xFFFE and issue 3 accepted writes → counter holds at 0xFFFF.
